// File: rtl/crossbar_nxm.sv
// crossbar_nxm
// ------------
// Parametrised N-master x M-slave request/acknowledge crossbar. The upper
// SEL_W address bits of each master pick the target slave, and the slave sees
// the remaining SADDR_W bits. Each slave has a registered arbiter. Once a
// master wins a slave it keeps it until that slave acks or the master drops
// its request. Read data returns one cycle after the read ack. A registered
// tag per slave routes that data back to the master that issued the read.
//
// Configuration macro:
//   XBAR_ROUND_ROBIN_EN  defined   -> round-robin arbitration with a pointer per slave
//                        undefined -> fixed priority, lowest master index wins
//
// Ports:
//   clock, reset   single rising-edge clock, synchronous active-high reset
//   master_req     [N_MASTERS]          request, held until ack
//   master_cmd     [N_MASTERS]          0 = read, 1 = write
//   master_addr    [N_MASTERS*ADDR_W]   packed per-master addresses
//   master_wdata   [N_MASTERS*DATA_W]   packed per-master write data
//   master_ack     [N_MASTERS]          request accepted
//   master_rdata   [N_MASTERS*DATA_W]   read data, valid the cycle after a read ack
//   slave_req      [N_SLAVES]           request to slave
//   slave_cmd      [N_SLAVES]           forwarded command
//   slave_addr     [N_SLAVES*SADDR_W]   low address bits of the owning master
//   slave_wdata    [N_SLAVES*DATA_W]    forwarded write data
//   slave_ack      [N_SLAVES]           slave accepts
//   slave_rdata    [N_SLAVES*DATA_W]    slave read data, valid the cycle after a read ack
module crossbar_nxm #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  localparam int SEL_W    = $clog2(N_SLAVES),
  localparam int SADDR_W  = ADDR_W - SEL_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          master_req,
  input  logic [N_MASTERS-1:0]          master_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0]   master_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   master_wdata,
  output logic [N_MASTERS-1:0]          master_ack,
  output logic [N_MASTERS*DATA_W-1:0]   master_rdata,
  output logic [N_SLAVES-1:0]           slave_req,
  output logic [N_SLAVES-1:0]           slave_cmd,
  output logic [N_SLAVES*SADDR_W-1:0]   slave_addr,
  output logic [N_SLAVES*DATA_W-1:0]    slave_wdata,
  input  logic [N_SLAVES-1:0]           slave_ack,
  input  logic [N_SLAVES*DATA_W-1:0]    slave_rdata
);

  localparam int MIDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {IDLE, OWNED} slot_state_t;

  slot_state_t                         state_q [N_SLAVES];
  slot_state_t                         state_d [N_SLAVES];
  logic [N_SLAVES-1:0][MIDX_W-1:0]     owner_q, owner_d;
  logic [N_SLAVES-1:0]                 pend_q, pend_d;
  logic [N_SLAVES-1:0][MIDX_W-1:0]     tag_q, tag_d;
`ifdef XBAR_ROUND_ROBIN_EN
  logic [N_SLAVES-1:0][MIDX_W-1:0]     ptr_q, ptr_d;
`endif
  logic [N_SLAVES-1:0][N_MASTERS-1:0]  cand;

  // Scan the candidates cyclically, starting at 'start'. The lowest offset
  // wins because the loop runs downward and later hits overwrite earlier ones.
  // The MSB of the result flags that some candidate was found.
  function automatic logic [MIDX_W:0] pick_master(input logic [N_MASTERS-1:0] cand_vec,
                                                  input int start);
    logic [MIDX_W:0] result;
    int m;
    result = '0;
    for (int o = N_MASTERS - 1; o >= 0; o--) begin
      m = (start + o) % N_MASTERS;
      if (cand_vec[m]) result = {1'b1, MIDX_W'(m)};
    end
    return result;
  endfunction

  // Candidate matrix. Master i competes for slave j when it is requesting and
  // its top address bits decode to j.
  always_comb begin
    cand = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        cand[j][i] = master_req[i] &&
                     (master_addr[i*ADDR_W + SADDR_W +: SEL_W] == SEL_W'(j));
      end
    end
  end

  // Next-state logic for each slave's arbiter. On an ack the current owner is
  // removed from the candidates before re-arbitration. A master that holds its
  // request through its own ack cycle therefore yields to any competitor, and
  // it cannot win the same slave twice in a row without a gap.
  always_comb begin
    logic [N_MASTERS-1:0] excl;
    logic [MIDX_W:0]      pick;
`ifdef XBAR_ROUND_ROBIN_EN
    int                   nxt;
`endif
    for (int j = 0; j < N_SLAVES; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      pend_d[j]  = 1'b0;
      tag_d[j]   = tag_q[j];
`ifdef XBAR_ROUND_ROBIN_EN
      ptr_d[j]   = ptr_q[j];
      nxt        = 0;
`endif
      excl = cand[j];
      pick = '0;
      case (state_q[j])
        IDLE: begin
`ifdef XBAR_ROUND_ROBIN_EN
          pick = pick_master(cand[j], int'(ptr_q[j]));
`else
          pick = pick_master(cand[j], 0);
`endif
          if (pick[MIDX_W]) begin
            state_d[j] = OWNED;
            owner_d[j] = pick[MIDX_W-1:0];
          end
        end
        OWNED: begin
          if (slave_ack[j]) begin
            pend_d[j] = ~master_cmd[owner_q[j]];
            tag_d[j]  = owner_q[j];
            excl[owner_q[j]] = 1'b0;
`ifdef XBAR_ROUND_ROBIN_EN
            nxt      = (int'(owner_q[j]) + 1) % N_MASTERS;
            ptr_d[j] = MIDX_W'(nxt);
            pick     = pick_master(excl, nxt);
`else
            pick     = pick_master(excl, 0);
`endif
            if (pick[MIDX_W]) owner_d[j] = pick[MIDX_W-1:0];
            else              state_d[j] = IDLE;
          end else if (!master_req[owner_q[j]]) begin
            state_d[j] = IDLE;
          end
        end
        default: state_d[j] = IDLE;
      endcase
    end
  end

  // State registers. Reset also clears any pending read route, so read data
  // that would have returned in the next cycle is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < N_SLAVES; j++) state_q[j] <= IDLE;
      owner_q <= '0;
      pend_q  <= '0;
      tag_q   <= '0;
`ifdef XBAR_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      for (int j = 0; j < N_SLAVES; j++) state_q[j] <= state_d[j];
      owner_q <= owner_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
`ifdef XBAR_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Datapath muxing. An owned slave forwards the owner's request fields, and
  // the slave's ack goes straight back to the owner. Read data is routed
  // through the tag registered at the read ack.
  always_comb begin
    slave_req    = '0;
    slave_cmd    = '0;
    slave_addr   = '0;
    slave_wdata  = '0;
    master_ack   = '0;
    master_rdata = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      if (state_q[j] == OWNED) begin
        slave_req[j] = master_req[owner_q[j]];
        slave_cmd[j] = master_cmd[owner_q[j]];
        slave_addr[j*SADDR_W +: SADDR_W] = master_addr[int'(owner_q[j])*ADDR_W +: SADDR_W];
        slave_wdata[j*DATA_W +: DATA_W]  = master_wdata[int'(owner_q[j])*DATA_W +: DATA_W];
        master_ack[owner_q[j]] = master_ack[owner_q[j]] | slave_ack[j];
      end
      if (pend_q[j]) begin
        master_rdata[int'(tag_q[j])*DATA_W +: DATA_W] = slave_rdata[j*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_crossbar_nxm.sv
// tb_crossbar_nxm
// ---------------
// Self-checking bench for crossbar_nxm. It uses a 2x2 instance for the
// protocol scenarios and a 4x4 instance for the parallel-routing scenario.
// Expected read returns and expected arbitration winners go into queues when
// the stimulus is driven. They are popped when the DUT should produce them.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
module tb_crossbar_nxm;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // 2x2 instance signals
  logic [1:0]   req2, cmd2, ack2, sreq2, scmd2, sack2;
  logic [63:0]  addr2, wdata2, rdata2, swdata2, srdata2;
  logic [61:0]  saddr2;

  // 4x4 instance signals
  logic [3:0]   req4, cmd4, ack4, sreq4, scmd4, sack4;
  logic [127:0] addr4, wdata4, rdata4, swdata4, srdata4;
  logic [119:0] saddr4;

  typedef struct {
    int          mst;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      owner_q[$];
  int      checks = 0;
  int      errors = 0;

  crossbar_nxm #(.N_MASTERS(2), .N_SLAVES(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .master_req(req2), .master_cmd(cmd2), .master_addr(addr2), .master_wdata(wdata2),
    .master_ack(ack2), .master_rdata(rdata2),
    .slave_req(sreq2), .slave_cmd(scmd2), .slave_addr(saddr2), .slave_wdata(swdata2),
    .slave_ack(sack2), .slave_rdata(srdata2)
  );

  crossbar_nxm #(.N_MASTERS(4), .N_SLAVES(4), .ADDR_W(32), .DATA_W(32)) dut4 (
    .clock(clock), .reset(reset),
    .master_req(req4), .master_cmd(cmd4), .master_addr(addr4), .master_wdata(wdata4),
    .master_ack(ack4), .master_rdata(rdata4),
    .slave_req(sreq4), .slave_cmd(scmd4), .slave_addr(saddr4), .slave_wdata(swdata4),
    .slave_ack(sack4), .slave_rdata(srdata4)
  );

  // Advance to just after the next rising edge, where the inputs are driven.
  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  // Return every bench-driven input except reset to idle.
  task automatic clear_inputs;
    req2 = '0; cmd2 = '0; addr2 = '0; wdata2 = '0; sack2 = '0; srdata2 = '0;
    req4 = '0; cmd4 = '0; addr4 = '0; wdata4 = '0; sack4 = '0; srdata4 = '0;
  endtask

  // While reset is held, outputs stay at zero even if requests are present.
  task automatic test_reset;
    clear_inputs();
    reset = 1'b1;
    req2  = 2'b01;
    req4  = 4'hF;
    next_cycle();
    next_cycle();
    @(negedge clock);
    checks++;
    if (sreq2 !== 2'b00) begin errors++; $display("[TB] FAIL reset_sreq2: got %b expected 00", sreq2); end
    checks++;
    if ({ack2, rdata2} !== '0) begin errors++; $display("[TB] FAIL reset_master_out: got %h expected 0", {ack2, rdata2}); end
    checks++;
    if ({scmd2, saddr2, swdata2} !== '0) begin errors++; $display("[TB] FAIL reset_slave_fields: got %h expected 0", {scmd2, saddr2, swdata2}); end
    checks++;
    if ({sreq4, ack4} !== 8'h00) begin errors++; $display("[TB] FAIL reset_4x4: got %h expected 00", {sreq4, ack4}); end
    next_cycle();
    reset = 1'b0;
    clear_inputs();
  endtask

  // Uncontended write from m0 to slave 0. The slave acks in its first request cycle.
  task automatic test_uncontended_write;
    next_cycle();
    req2 = 2'b01; cmd2 = 2'b01; addr2[31:0] = 32'h0000_0010; wdata2[31:0] = 32'hA5A5_A5A5;
    @(negedge clock);
    checks++;
    if (sreq2 !== 2'b00) begin errors++; $display("[TB] FAIL wr_first_cycle_sreq: got %b expected 00", sreq2); end
    next_cycle();
    sack2 = 2'b01;
    @(negedge clock);
    checks++;
    if (sreq2 !== 2'b01) begin errors++; $display("[TB] FAIL wr_sreq: got %b expected 01", sreq2); end
    checks++;
    if (saddr2[30:0] !== 31'h10) begin errors++; $display("[TB] FAIL wr_saddr: got %h expected 10", saddr2[30:0]); end
    checks++;
    if (scmd2[0] !== 1'b1 || swdata2[31:0] !== 32'hA5A5_A5A5) begin
      errors++; $display("[TB] FAIL wr_cmd_wdata: got %b/%h expected 1/a5a5a5a5", scmd2[0], swdata2[31:0]);
    end
    checks++;
    if (ack2 !== 2'b01) begin errors++; $display("[TB] FAIL wr_ack: got %b expected 01", ack2); end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    checks++;
    if ({sreq2, ack2, rdata2} !== '0) begin errors++; $display("[TB] FAIL wr_after: got %h expected 0", {sreq2, ack2, rdata2}); end
  endtask

  // m1 reads from the upper half of the address space, which maps to slave 1.
  task automatic test_routing_read;
    rd_exp_t e;
    next_cycle();
    req2 = 2'b10; cmd2 = 2'b00; addr2[63:32] = 32'h8000_0004;
    next_cycle();
    sack2 = 2'b10;
    @(negedge clock);
    checks++;
    if (sreq2 !== 2'b10) begin errors++; $display("[TB] FAIL rd_sreq: got %b expected 10", sreq2); end
    checks++;
    if (saddr2[61:31] !== 31'h4 || scmd2[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_saddr_cmd: got %h/%b expected 4/0", saddr2[61:31], scmd2[1]);
    end
    checks++;
    if (ack2 !== 2'b10) begin errors++; $display("[TB] FAIL rd_ack: got %b expected 10", ack2); end
    e.mst = 1; e.data = 32'hDEAD_BEEF;
    rd_q.push_back(e);
    next_cycle();
    clear_inputs();
    srdata2[63:32] = 32'hDEAD_BEEF;
    @(negedge clock);
    e = rd_q.pop_front();
    checks++;
    if (rdata2[e.mst*32 +: 32] !== e.data) begin
      errors++; $display("[TB] FAIL rd_rdata_m1: got %h expected %h", rdata2[e.mst*32 +: 32], e.data);
    end
    checks++;
    if (rdata2[31:0] !== 32'h0) begin errors++; $display("[TB] FAIL rd_rdata_m0: got %h expected 0", rdata2[31:0]); end
  endtask

  // Reset is sampled at the same edge as m0's read ack. The read return
  // expected in the next cycle must be dropped.
  task automatic test_reset_mid_read;
    next_cycle();
    req2 = 2'b01; cmd2 = 2'b00; addr2[31:0] = 32'h0000_0020;
    next_cycle();
    sack2 = 2'b01;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (ack2 !== 2'b01) begin errors++; $display("[TB] FAIL rst_mid_ack: got %b expected 01", ack2); end
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    srdata2[31:0] = 32'h1234_5678;
    @(negedge clock);
    checks++;
    if (rdata2 !== 64'h0) begin errors++; $display("[TB] FAIL rst_mid_rdata: got %h expected 0", rdata2); end
    checks++;
    if (sreq2 !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_sreq: got %b expected 00", sreq2); end
  endtask

  // m0 and m1 both hold requests to slave 0, and the slave acks every cycle.
  // Ownership must alternate with no gap cycles.
  task automatic test_contention;
    logic [1:0] exp_ack;
    int         exp_owner;
    owner_q = {0, 1, 0, 1};
    next_cycle();
    req2 = 2'b11; cmd2 = 2'b11;
    addr2 = {32'h0000_0004, 32'h0000_0000};
    wdata2 = {32'h1111_1111, 32'h0000_0000};
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      sack2 = 2'b01;
      @(negedge clock);
      exp_owner = owner_q.pop_front();
      exp_ack   = 2'b01 << exp_owner;
      checks++;
      if (ack2 !== exp_ack || sreq2[0] !== 1'b1) begin
        errors++; $display("[TB] FAIL contention_owner_%0d: got ack %b sreq %b expected ack %b sreq 1", c, ack2, sreq2[0], exp_ack);
      end
      checks++;
      if (saddr2[30:0] !== 31'(exp_owner * 4)) begin
        errors++; $display("[TB] FAIL contention_addr_%0d: got %h expected %h", c, saddr2[30:0], exp_owner * 4);
      end
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    checks++;
    if (sreq2 !== 2'b00) begin errors++; $display("[TB] FAIL contention_drain: got %b expected 00", sreq2); end
  endtask

  // A lone master that keeps its request and the slave ack asserted wins only
  // every other cycle. Its own request in the ack cycle does not re-win the slave.
  task automatic test_same_master_b2b;
    logic [1:0] exp_pat [4];
    exp_pat = '{2'b00, 2'b01, 2'b00, 2'b01};
    next_cycle();
    req2 = 2'b01; cmd2 = 2'b01; addr2[31:0] = 32'h0000_0040;
    sack2 = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (ack2 !== exp_pat[c] || sreq2 !== exp_pat[c]) begin
        errors++; $display("[TB] FAIL same_master_cycle_%0d: got ack %b sreq %b expected %b", c, ack2, sreq2, exp_pat[c]);
      end
      next_cycle();
    end
    clear_inputs();
    @(negedge clock);
  endtask

  // m0 wins slave 1 and then drops its request before any ack. The slave goes
  // idle, and m1's pending request is granted at the following edge.
  task automatic test_abort;
    next_cycle();
    req2 = 2'b01; cmd2 = 2'b11; addr2 = {32'h8000_0008, 32'h8000_0000};
    next_cycle();
    req2 = 2'b11;
    @(negedge clock);
    checks++;
    if (sreq2 !== 2'b10 || ack2 !== 2'b00) begin
      errors++; $display("[TB] FAIL abort_owned: got sreq %b ack %b expected 10/00", sreq2, ack2);
    end
    next_cycle();
    req2 = 2'b10;
    @(negedge clock);
    checks++;
    if (sreq2 !== 2'b00) begin errors++; $display("[TB] FAIL abort_drop: got %b expected 00", sreq2); end
    next_cycle();
    @(negedge clock);
    checks++;
    if (sreq2 !== 2'b00) begin errors++; $display("[TB] FAIL abort_idle: got %b expected 00", sreq2); end
    next_cycle();
    sack2 = 2'b10;
    @(negedge clock);
    checks++;
    if (sreq2 !== 2'b10 || saddr2[61:31] !== 31'h8 || ack2 !== 2'b10) begin
      errors++; $display("[TB] FAIL abort_regrant: got sreq %b addr %h ack %b expected 10/8/10", sreq2, saddr2[61:31], ack2);
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
  endtask

  // In the 4x4 instance, master i reads from slave 3-i. All slaves are driven
  // in the same cycle, and all four read returns come back in the same cycle.
  task automatic test_parallel_4x4;
    rd_exp_t e;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      addr4[i*32 +: 32] = {2'(3 - i), 30'(256 + i * 16)};
    end
    req4 = 4'hF; cmd4 = 4'h0;
    next_cycle();
    sack4 = 4'hF;
    @(negedge clock);
    checks++;
    if (sreq4 !== 4'hF || ack4 !== 4'hF) begin
      errors++; $display("[TB] FAIL par_req_ack: got sreq %h ack %h expected f/f", sreq4, ack4);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (saddr4[(3 - i)*30 +: 30] !== 30'(256 + i * 16)) begin
        errors++; $display("[TB] FAIL par_saddr_s%0d: got %h expected %h", 3 - i, saddr4[(3 - i)*30 +: 30], 256 + i * 16);
      end
      e.mst = i; e.data = 32'hC0DE_0000 | 32'(3 - i);
      rd_q.push_back(e);
    end
    next_cycle();
    clear_inputs();
    for (int j = 0; j < 4; j++) srdata4[j*32 +: 32] = 32'hC0DE_0000 | 32'(j);
    @(negedge clock);
    while (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      checks++;
      if (rdata4[e.mst*32 +: 32] !== e.data) begin
        errors++; $display("[TB] FAIL par_rdata_m%0d: got %h expected %h", e.mst, rdata4[e.mst*32 +: 32], e.data);
      end
    end
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_uncontended_write();
    test_routing_read();
    test_reset_mid_read();
    test_contention();
    test_same_master_b2b();
    test_abort();
    test_parallel_4x4();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/crossbar_nxm.md
# crossbar_nxm

Parametrised N-master × M-slave request/acknowledge crossbar; successor to the fixed 2×2 crossbar, same per-port protocol (req, cmd, addr, wdata, ack, rdata). Sits between bus masters and memory-mapped slaves. Upper address bits select the slave. A registered per-slave arbiter with grant locking resolves contention. Read data returns one cycle after ack, routed by a registered tag.

## Interface
- N_MASTERS, 2, number of master ports (≥2)
- N_SLAVES, 2, number of slave ports (power of 2, ≥2); SEL_W = log2(N_SLAVES)
- ADDR_W, 32, master address width; slave address width SADDR_W = ADDR_W−SEL_W
- DATA_W, 32, wdata/rdata width
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- master_req  in  N_MASTERS  request, held until ack
- master_cmd  in  N_MASTERS  0 = read, 1 = write
- master_addr  in  N_MASTERS*ADDR_W  packed, master i at [i*ADDR_W +: ADDR_W]
- master_wdata  in  N_MASTERS*DATA_W  write data
- master_ack  out  N_MASTERS  request accepted
- master_rdata  out  N_MASTERS*DATA_W  read data, valid cycle after read ack
- slave_req  out  N_SLAVES  request to slave
- slave_cmd  out  N_SLAVES  forwarded cmd
- slave_addr  out  N_SLAVES*SADDR_W  master_addr[SADDR_W-1:0] of owner
- slave_wdata  out  N_SLAVES*DATA_W  forwarded wdata
- slave_ack  in  N_SLAVES  slave accepts
- slave_rdata  in  N_SLAVES*DATA_W  slave read data, valid cycle after read ack

## Operation
- Target slave of master i: tgt(i) = master_addr_i[ADDR_W-1 -: SEL_W].
- Per slave j: state IDLE or OWNED(owner, registered index); rr pointer ptr_j.
- Candidates for slave j: master i with master_req[i] && tgt(i)==j.
- IDLE: if candidates exist, pick first candidate at or after ptr_j (cyclic). Register OWNED(pick) at the clock edge. slave_req[j]=0 in IDLE; slave_ack[j] is ignored.
- OWNED(k): slave_req[j]=master_req[k]. slave_cmd/addr/wdata are taken from master k. master_ack[k]=slave_ack[j] (combinational).
- OWNED(k) and slave_ack[j]: ptr_j←k+1 mod N_MASTERS. Re-arbitrate in the same cycle among candidates excluding k → OWNED(next), or IDLE if none.
- OWNED(k) and master_req[k]=0 without ack (abort): → IDLE. ptr_j unchanged.
- Unused slave outputs are driven 0. master_ack bits not owned anywhere are 0.
- Read tag: on a read ack (slave_ack[j] && slave_cmd[j]==0), register pend_j←1 and tag_j←k; otherwise pend_j←0.
- master_rdata[k] = slave_rdata[j] for the j with pend_j && tag_j==k, else 0. At most one j matches, because a master gets at most one ack per cycle.

## Timing
- Reset values: all states IDLE, ptr=0, pend=0. Outputs: slave_req=0, slave_cmd/addr/wdata=0, master_ack=0, master_rdata=0.
- Uncontended latency: master_req rises in cycle t → slave_req in t+1. If the slave acks in t+1, master_ack is also in t+1. Read data reaches master_rdata in t+2.
- Back-to-back: with a competing requester present at ack, the next owner's slave_req is asserted in the cycle after ack. No idle gap.
- Same-master back-to-back: the master's own req in its ack cycle never re-wins that slave. Its next transaction is arbitrated from the following cycle.
- Simultaneous acks on different slaves for different masters: independent. Each rdata route is separate.
- reset during OWNED or pend: all state clears at that edge. Any rdata due next cycle is dropped (0).

## Configuration
- XBAR_ROUND_ROBIN_EN defined: round-robin arbitration as above, with ptr_j registers present.
- Undefined: fixed priority, lowest master index wins. ptr_j is not instantiated. The "exclude k at ack" rule is kept, so the next owner comes from the other candidates.

## Test plan
- Reset mid-read: m0 read slave 0 acked, reset in the next cycle → master_rdata[0]=0, all slave_req=0 that cycle.
- Uncontended 2×2: m0 writes addr 0x0000_0010, wdata 0xA5A5_A5A5. Expect slave_req[0] at t+1 with slave_addr=0x10 and slave_cmd=1. Slave acks at t+1 → master_ack[0] at t+1.
- Routing by MSB: m1 reads 0x8000_0004. Expect slave_req[1]=1 and slave_addr=0x0000_0004. Slave returns 0xDEAD_BEEF the cycle after ack → master_rdata[1]=0xDEAD_BEEF one cycle after master_ack[1].
- Contention, RR: m0 and m1 both hold req to slave 0; slave acks every cycle. Expect owners in the order m0, m1, m0, m1 with no gap cycles. Without XBAR_ROUND_ROBIN_EN, expect the same alternation driven by ack-exclusion.
- 4×4 parallel: N_MASTERS=4, N_SLAVES=4, each master i targets slave 3−i. All four slave_req assert in the same cycle. Four read returns are routed to the correct masters in the same cycle.
- Abort: m0 is granted on slave 1 and drops req before ack. Expect slave_req[1]=0 that cycle, then IDLE. A pending m1 request is granted the following cycle.
